// File: rtl/dp_seq.sv
// dp_seq: streaming signed dot-product sequencer.
// Accepts cfg_len operand pairs, issues nonzero pairs to an external
// two-stage multiplier, accumulates the returned truncated products and
// presents the wrapped DW_ACC-bit sum through a valid/ready result port.
module dp_seq #(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ACC  = 24,
  parameter int unsigned DW_LEN  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DW_LEN-1:0]         cfg_len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DW_DATA-1:0] s_a,
  input  logic signed [DW_DATA-1:0] s_b,
  output logic                      mul_enable,
  output logic [1:0]                mul_valid,
  output logic signed [DW_DATA-1:0] mul_a,
  output logic signed [DW_DATA-1:0] mul_b,
  input  logic signed [DW_DATA-1:0] mul_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DW_ACC-1:0]  out_data,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                    state_q;
  logic [DW_LEN-1:0]         count_q;
  logic [DW_LEN-1:0]         len_q;
  logic signed [DW_ACC-1:0]  acc_q;
  logic                      vld_d1_q;
  logic                      vld_d2_q;

  logic                      accept;
  logic                      nonzero;
  logic                      issue;
  logic [DW_LEN-1:0]         count_inc;
  logic signed [DW_ACC-1:0]  prod_ext;

  assign count_inc = count_q + {{(DW_LEN-1){1'b0}}, 1'b1};
  assign prod_ext  = {{(DW_ACC-DW_DATA){mul_out[DW_DATA-1]}}, mul_out};

  // Handshake, zero-skip issue and state-decoded outputs; reset blanks them in-cycle.
  always_comb begin
    s_ready    = !reset && (state_q == StRun) && (count_q < len_q);
    accept     = s_valid && s_ready;
    nonzero    = (s_a != '0) && (s_b != '0);
    issue      = accept && nonzero;
    mul_valid  = issue ? 2'b11 : 2'b00;
    mul_a      = issue ? s_a : '0;
    mul_b      = issue ? s_b : '0;
    mul_enable = !reset && ((state_q == StRun) || (state_q == StDrain));
    busy       = !reset && (state_q != StIdle);
    out_valid  = !reset && (state_q == StDone);
    out_data   = out_valid ? acc_q : '0;
  end

  // Sequencer FSM, issue-tag pipeline and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      vld_d1_q <= 1'b0;
      vld_d2_q <= 1'b0;
    end else begin
      // Tags follow the multiplier pipeline, so they only advance when it does.
      if (mul_enable) begin
        vld_d1_q <= issue;
        vld_d2_q <= vld_d1_q;
      end
      // vld_d2 marks mul_out as holding the product issued two cycles earlier.
      if (vld_d2_q) begin
        acc_q <= acc_q + prod_ext;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= cfg_len;
            count_q <= '0;
            acc_q   <= '0;
            state_q <= (cfg_len == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (accept) begin
            count_q <= count_inc;
            if (count_inc == len_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // With vld_d1 clear the last pending product lands on this edge.
          if (!vld_d1_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dp_seq.md
DP_SEQ -- requirements
Module: dp_seq

Interface
REQ-001 SHALL have parameter DW_DATA, default 8, operand and product width (signed).
REQ-002 SHALL have parameter DW_ACC, default 24, accumulator width (signed, DW_ACC > DW_DATA).
REQ-003 SHALL have parameter DW_LEN, default 8, pair-count width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a dot product; honoured only in IDLE.
REQ-007 SHALL have port cfg_len  input  DW_LEN  number of operand pairs, sampled when start is honoured.
REQ-008 SHALL have port s_valid / s_ready  input / output  1 / 1  operand-pair stream handshake.
REQ-009 SHALL have port s_a, s_b  input  DW_DATA each  signed operand pair.
REQ-010 SHALL have port mul_enable  output  1  multiplier pipeline enable.
REQ-011 SHALL have port mul_valid  output  2  operand-latch strobes (bit1 = a, bit0 = b).
REQ-012 SHALL have port mul_a, mul_b  output  DW_DATA each  operands to the multiplier.
REQ-013 SHALL have port mul_out  input  DW_DATA  registered, truncated product from the multiplier.
REQ-014 SHALL have port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-015 SHALL have port out_data  output  DW_ACC  accumulated dot product.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 with cfg_len>0 -> RUN, with count and acc cleared; start=1 with cfg_len=0 -> DONE, acc=0.
REQ-019 RUN: s_ready=1 while count<len; a pair is accepted on s_valid&&s_ready; count increments per accepted pair.
REQ-020 SHALL issue an accepted pair combinationally in the same cycle: mul_a=s_a, mul_b=s_b, mul_valid=2'b11.
REQ-021 Zero skip: a pair with s_a==0 or s_b==0 SHALL be accepted and counted, with mul_valid=2'b00.
REQ-022 mul_valid SHALL be 2'b00 in every cycle without an issued pair; mul_a and mul_b are then don't-care.
REQ-023 mul_enable SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-024 SHALL track issue tags vld_d1 <= issued and vld_d2 <= vld_d1, updated only while mul_enable=1.
REQ-025 SHALL perform acc <= acc + sign_extend(mul_out) at the edge ending any cycle with vld_d2=1; there is no other acc update.
REQ-026 Product timing: a pair issued in cycle t SHALL be accumulated at the edge ending cycle t+2.
REQ-027 Stale mul_out values (tags 0) SHALL never be accumulated.
REQ-028 RUN -> DRAIN at the edge on which the pair making count==len is accepted.
REQ-029 DRAIN -> DONE at the edge ending a cycle with vld_d1=0; the final accumulate SHALL occur on that same edge.
REQ-030 Latency: if the last pair is accepted in cycle c and is nonzero, out_valid SHALL rise in cycle c+3; otherwise out_valid SHALL rise no later than c+3.
REQ-031 DONE: out_valid=1 and out_data=acc, held stable until out_ready=1, then -> IDLE at that edge.
REQ-032 out_data SHALL be 0 whenever out_valid=0.
REQ-033 Accumulation SHALL wrap as two's complement in DW_ACC bits; products are the DW_DATA-bit truncation delivered by the multiplier.
REQ-034 start SHALL be ignored in RUN, DRAIN and DONE; s_ready SHALL be 0 outside RUN.
REQ-035 If start and out_ready both arrive in DONE, only the handshake SHALL be taken; the next start is honoured in IDLE.

Reset
REQ-036 reset=1 SHALL force state IDLE; count, acc, vld_d1 and vld_d2 to 0; and s_ready, out_valid, out_data, busy, mul_enable, mul_valid, mul_a and mul_b all to 0.
REQ-037 reset SHALL take priority over every other input, including mid-RUN and mid-DRAIN; in-flight products SHALL be discarded.

Verification
REQ-038 Basic: len=3, pairs (2,3),(-4,5),(7,1) back-to-back -> mul_valid=11 three cycles, out_data=-7, out_valid in c+3.
REQ-039 Zero skip: len=4, pairs (0,9),(3,3),(5,0),(-2,-2) -> mul_valid=11 only for the 2nd and 4th pairs, out_data=13.
REQ-040 Truncation/gaps: len=2, pairs (12,12),(1,1) with 2 idle cycles between -> products -112, 1; out_data=-111.
REQ-041 Empty and backpressure: start with len=0 -> out_valid next cycle, out_data=0; hold out_ready=0 for 5 cycles -> out_valid and out_data stable, start ignored.
REQ-042 Reset mid-op: reset in DRAIN after (5,5) issued -> all outputs 0; new run with len=1, pair (1,2) -> out_data=2, with no 25 leakage.
